// File: rtl/peripheral_dbg_pu_riscv_bus_xfer_pkg.sv
// Shared types and defaults for the debug bus-transfer consumer.
package peripheral_dbg_pu_riscv_bus_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_BUS     = 2'd2,
    ST_DONE    = 2'd3
  } xfer_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/peripheral_dbg_pu_riscv_bus_xfer.sv
// Destination-domain consumer of the debug request syncflop: runs one
// single-beat Wishbone classic transfer per request and flips ACK_TOGGLE on completion.
//
// state   | meaning
// IDLE    | waiting for REQ_PENDING
// CAPTURE | REQ_CLR pulse, latch quasi-static request fields
// BUS     | CYC/STB asserted, waiting for ERR/ACK/timeout
// DONE    | guard cycle with bus idle
module peripheral_dbg_pu_riscv_bus_xfer
  import peripheral_dbg_pu_riscv_bus_xfer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                    RESET,
  input  logic                    DEST_CLK,
  input  logic                    REQ_PENDING,
  output logic                    REQ_CLR,
  input  logic [ADDR_WIDTH-1:0]   ADDR_IN,
  input  logic [DATA_WIDTH-1:0]   DATA_IN,
  input  logic                    WE_IN,
  input  logic [DATA_WIDTH/8-1:0] SEL_IN,
  output logic [ADDR_WIDTH-1:0]   WB_ADR_O,
  output logic [DATA_WIDTH-1:0]   WB_DAT_O,
  output logic                    WB_WE_O,
  output logic [DATA_WIDTH/8-1:0] WB_SEL_O,
  output logic                    WB_CYC_O,
  output logic                    WB_STB_O,
  input  logic [DATA_WIDTH-1:0]   WB_DAT_I,
  input  logic                    WB_ACK_I,
  input  logic                    WB_ERR_I,
  output logic [DATA_WIDTH-1:0]   DATA_OUT,
  output logic                    ERR_OUT,
  output logic                    ACK_TOGGLE
);

  // A zero-width counter is not legal, so TIMEOUT=0 still keeps one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  xfer_state_e             state_q;
  logic                    req_clr_q;
  logic                    cyc_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    err_q;
  logic                    toggle_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    timeout_d;
  logic                    fail_d;

  always_comb begin
    timeout_d = 1'b0;
    if (TIMEOUT > 0)
      timeout_d = (cnt_q == CNT_LAST) && !WB_ACK_I && !WB_ERR_I;
    fail_d = WB_ERR_I || timeout_d;
  end

  always_ff @(posedge DEST_CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      req_clr_q  <= 1'b0;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      toggle_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      req_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ_PENDING) begin
            state_q   <= ST_CAPTURE;
            req_clr_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          adr_q   <= ADDR_IN;
          dat_q   <= DATA_IN;
          we_q    <= WE_IN;
          sel_q   <= SEL_IN;
          cnt_q   <= '0;
          cyc_q   <= 1'b1;
          state_q <= ST_BUS;
        end
        ST_BUS: begin
          if (fail_d) begin
            data_out_q <= '0;
            err_q      <= 1'b1;
            toggle_q   <= ~toggle_q;
            cyc_q      <= 1'b0;
            state_q    <= ST_DONE;
          end else if (WB_ACK_I) begin
            if (!we_q) data_out_q <= WB_DAT_I;
            err_q    <= 1'b0;
            toggle_q <= ~toggle_q;
            cyc_q    <= 1'b0;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign REQ_CLR    = req_clr_q;
  assign WB_ADR_O   = adr_q;
  assign WB_DAT_O   = dat_q;
  assign WB_WE_O    = we_q;
  assign WB_SEL_O   = sel_q;
  assign WB_CYC_O   = cyc_q;
  assign WB_STB_O   = cyc_q;
  assign DATA_OUT   = data_out_q;
  assign ERR_OUT    = err_q;
  assign ACK_TOGGLE = toggle_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_bus_xfer.sv
// Scoreboard bench for peripheral_dbg_pu_riscv_bus_xfer: directed requests push
// expected completions, a monitor pops them on every ACK_TOGGLE flip.
module tb_peripheral_dbg_pu_riscv_bus_xfer;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        tog;
  } exp_t;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_PENDING = 1'b0;
  logic        REQ_CLR;
  logic [31:0] ADDR_IN = '0;
  logic [31:0] DATA_IN = '0;
  logic        WE_IN = 1'b0;
  logic [3:0]  SEL_IN = '0;
  logic [31:0] WB_ADR_O, WB_DAT_O, DATA_OUT;
  logic        WB_WE_O, WB_CYC_O, WB_STB_O, ERR_OUT, ACK_TOGGLE;
  logic [3:0]  WB_SEL_O;
  logic [31:0] WB_DAT_I = '0;
  logic        WB_ACK_I = 1'b0;
  logic        WB_ERR_I = 1'b0;

  // second instance with the timeout disabled
  logic        rst0 = 1'b1;
  logic        d0_req = 1'b0;
  logic        d0_clr, d0_we, d0_cyc, d0_stb, d0_err, d0_tog;
  logic [31:0] d0_adr, d0_dat, d0_dout;
  logic [3:0]  d0_sel;
  logic [31:0] d0_zero32 = '0;
  logic        d0_zero = 1'b0;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] exp_data = '0;
  logic        exp_err = 1'b0;
  logic        exp_tog = 1'b0;

  int          s_mode = 0;   // 0 ack, 1 err+ack, 2 no response
  int          s_wait = 0;
  logic [31:0] s_rdata = '0;
  int          scnt = 0;
  logic        prev_tog = 1'b0;

  always #5 clk = ~clk;

  peripheral_dbg_pu_riscv_bus_xfer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .RESET(RESET), .DEST_CLK(clk), .REQ_PENDING(REQ_PENDING), .REQ_CLR(REQ_CLR),
    .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN), .WE_IN(WE_IN), .SEL_IN(SEL_IN),
    .WB_ADR_O(WB_ADR_O), .WB_DAT_O(WB_DAT_O), .WB_WE_O(WB_WE_O), .WB_SEL_O(WB_SEL_O),
    .WB_CYC_O(WB_CYC_O), .WB_STB_O(WB_STB_O), .WB_DAT_I(WB_DAT_I),
    .WB_ACK_I(WB_ACK_I), .WB_ERR_I(WB_ERR_I), .DATA_OUT(DATA_OUT),
    .ERR_OUT(ERR_OUT), .ACK_TOGGLE(ACK_TOGGLE));

  peripheral_dbg_pu_riscv_bus_xfer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut_t0 (
    .RESET(rst0), .DEST_CLK(clk), .REQ_PENDING(d0_req), .REQ_CLR(d0_clr),
    .ADDR_IN(d0_zero32), .DATA_IN(d0_zero32), .WE_IN(d0_zero), .SEL_IN(4'hF),
    .WB_ADR_O(d0_adr), .WB_DAT_O(d0_dat), .WB_WE_O(d0_we), .WB_SEL_O(d0_sel),
    .WB_CYC_O(d0_cyc), .WB_STB_O(d0_stb), .WB_DAT_I(d0_zero32),
    .WB_ACK_I(d0_zero), .WB_ERR_I(d0_zero), .DATA_OUT(d0_dout),
    .ERR_OUT(d0_err), .ACK_TOGGLE(d0_tog));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: terminates on the (s_wait)th STB cycle, counting from 0.
  always @(negedge clk) begin
    if (WB_STB_O && !RESET) begin
      WB_ACK_I = (s_mode != 2) && (scnt == s_wait);
      WB_ERR_I = (s_mode == 1) && (scnt == s_wait);
      WB_DAT_I = s_rdata;
      scnt++;
    end else begin
      WB_ACK_I = 1'b0;
      WB_ERR_I = 1'b0;
      scnt = 0;
    end
  end

  // Monitor: every toggle flip must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (RESET) begin
      prev_tog = 1'b0;
    end else if (ACK_TOGGLE !== prev_tog) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty_on_flip", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("data_out", DATA_OUT, e.data);
        chk("err_out", ERR_OUT, e.err);
        chk("ack_toggle", ACK_TOGGLE, e.tog);
      end
      prev_tog = ACK_TOGGLE;
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        input logic [3:0] sel, input int mode, input int wt,
                        input logic [31:0] rdata, input int exp_dly, input int exp_len,
                        input bit glitch, output int dly);
    int n;
    exp_t e;
    s_mode = mode; s_wait = wt; s_rdata = rdata;
    ADDR_IN = addr; DATA_IN = wdata; WE_IN = we; SEL_IN = sel;
    REQ_PENDING = 1'b1;
    if (mode == 0) begin
      if (!we) exp_data = rdata;
      exp_err = 1'b0;
    end else begin
      exp_data = '0;
      exp_err = 1'b1;
    end
    exp_tog = ~exp_tog;
    e.data = exp_data; e.err = exp_err; e.tog = exp_tog;
    sb.push_back(e);
    dly = 0;
    do begin @(negedge clk); dly++; end while (!REQ_CLR && dly < 20);
    chk("req_clr_delay", dly, exp_dly);
    chk("stb_low_in_capture", WB_STB_O, 0);
    REQ_PENDING = 1'b0;
    @(negedge clk);
    chk("req_clr_one_cycle", REQ_CLR, 0);
    chk("cyc_first_bus", WB_CYC_O, 1);
    chk("wb_adr", WB_ADR_O, addr);
    chk("wb_we", WB_WE_O, we);
    chk("wb_sel", WB_SEL_O, sel);
    if (we) chk("wb_dat", WB_DAT_O, wdata);
    n = 0;
    while (WB_STB_O && n < 40) begin
      n++;
      if (glitch) REQ_PENDING = (n == 2);
      @(negedge clk);
    end
    REQ_PENDING = 1'b0;
    chk("stb_len", n, exp_len);
    chk("cyc_low_done", WB_CYC_O, 0);
  endtask

  initial begin
    int dly, n, seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly, n, seen;
    repeat (3) @(negedge clk);
    chk("rst_cyc", WB_CYC_O, 0);
    chk("rst_stb", WB_STB_O, 0);
    chk("rst_clr", REQ_CLR, 0);
    RESET = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    chk("rst_tog", ACK_TOGGLE, 0);
    chk("rst_err", ERR_OUT, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_adr", WB_ADR_O, 0);
    chk("rst_wedat", {WB_WE_O, WB_SEL_O, WB_DAT_O}, 0);

    // zero-wait read
    do_req(32'h1000, 32'h0, 1'b0, 4'hF, 0, 0, 32'hDEADBEEF, 1, 1, 0, dly);
    repeat (2) @(negedge clk);
    // write, 3 wait states
    do_req(32'h2004, 32'h12345678, 1'b1, 4'b0011, 0, 3, 32'hFFFF0000, 1, 4, 0, dly);
    repeat (2) @(negedge clk);
    // ERR and ACK together
    do_req(32'h3000, 32'h0, 1'b0, 4'hF, 1, 1, 32'h55555555, 1, 2, 0, dly);
    repeat (2) @(negedge clk);
    // no response, timeout of 8
    do_req(32'h4000, 32'h0, 1'b0, 4'hF, 2, 0, 32'h0, 1, 8, 0, dly);
    repeat (2) @(negedge clk);
    // successful ack clears the error flag
    do_req(32'h5000, 32'h0, 1'b0, 4'h1, 0, 2, 32'hCAFEF00D, 1, 3, 0, dly);
    repeat (2) @(negedge clk);

    // back-to-back, second one with a REQ_PENDING glitch in BUS
    do_req(32'h6000, 32'h0, 1'b0, 4'hF, 0, 0, 32'h11111111, 1, 1, 0, dly);
    do_req(32'h6004, 32'hA0B0C0D0, 1'b1, 4'hC, 0, 3, 32'h0, 2, 4, 1, dly);
    chk("b2b_gap", 1 + dly, 3);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (WB_STB_O || REQ_CLR) seen++;
    end
    chk("glitch_ignored", seen, 0);

    // reset in the middle of a bus cycle
    s_mode = 2;
    ADDR_IN = 32'h7000; WE_IN = 1'b0; SEL_IN = 4'hF;
    REQ_PENDING = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!REQ_CLR && n < 20);
    REQ_PENDING = 1'b0;
    repeat (3) @(negedge clk);
    chk("stb_before_reset", WB_STB_O, 1);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_cyc", WB_CYC_O, 0);
    chk("mid_rst_stb", WB_STB_O, 0);
    chk("mid_rst_tog", ACK_TOGGLE, 0);
    chk("mid_rst_data", DATA_OUT, 0);
    chk("mid_rst_err", ERR_OUT, 0);
    chk("mid_rst_adr", WB_ADR_O, 0);
    sb.delete();
    exp_tog = 1'b0; exp_data = '0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    repeat (2) @(negedge clk);
    do_req(32'h8000, 32'h0, 1'b0, 4'hF, 0, 1, 32'hA5A5A5A5, 1, 2, 0, dly);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // timeout disabled: bus stays busy indefinitely
    d0_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!d0_clr && n < 20);
    chk("t0_req_clr", d0_clr, 1);
    d0_req = 1'b0;
    @(negedge clk);
    n = 0;
    while (d0_stb && n < 1100) begin n++; @(negedge clk); end
    chk("t0_stb_len", n, 1100);
    chk("t0_no_toggle", d0_tog, 0);
    rst0 = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
